score_digit_renderer: RTL and testbench
=======================================

// Module: score_digit_renderer
// PURPOSE
//  Video stage that draws an N-digit BCD score, upstream of the seven-segment decoder and the segments-to-bitmap stage.
//  Keeps the score counter and maps beam position (hpos/vpos) to a digit code and a glyph line (0..4).
//  Samples the 5-bit bitmap row returned by the decoder/bitmap stages and drives a registered pixel.
//  Score changes are double-buffered and committed at frame start, so digits never tear mid-frame.
// PARAMETERS
//  NUM_DIGITS  4  digits drawn; score width is 4*NUM_DIGITS bits
//  X0          16 screen x of the left edge of digit 0 (most significant)
//  Y0          8  screen y of the top edge of glyph line 0
//  SCALE_LOG2  2  each glyph cell is 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
//  PITCH       8  glyph cells per digit (5 drawn + 3 gap); must be >= 5 and a power of 2
// PORTS
//  clk         in   1   pixel clock
//  reset_n     in   1   asynchronous, active-low reset
//  hpos        in   9   beam x
//  vpos        in   9   beam y
//  display_on  in   1   beam is in the visible area
//  score_add   in   4   BCD delta, 0..9; values 10..15 are ignored
//  score_inc   in   1   one-cycle pulse: add score_add to the working score
//  score_clr   in   1   one-cycle pulse: clear the working score and overflow
//  digit       out  4   BCD code sent to the seven-segment decoder
//  line        out  3   glyph line sent to segments-to-bitmap; 7 when outside the box
//  bits        in   5   bitmap row returned (combinational path digit/line -> bits); bits[4] is the leftmost column
//  pixel       out  1   registered pixel output
//  score_bcd   out  4*NUM_DIGITS  committed (displayed) score
//  overflow    out  1   sticky; the working score has wrapped past all-9s
// BEHAVIOUR
//  Reset (async assert, sync release): working and committed score = 0; overflow = 0; digit = 0; line = 7; pixel = 0.
//  Score arithmetic:
//   - score_inc with a valid score_add performs a BCD add with ripple carry across all digits, in one cycle.
//   - Carry out of the top digit wraps the score modulo 10^NUM_DIGITS and sets overflow.
//   - score_clr takes priority over a same-cycle score_inc (result 0, overflow 0).
//   - score_inc with score_add >= 10: no change to score or overflow.
//  Commit: the cycle after hpos==0 && vpos==0, score_bcd <= working score.
//   - An inc in that same cycle is not included in this commit; it appears at the next frame.
//  Box geometry, with cx = (hpos-X0)>>SCALE_LOG2 and cy = (vpos-Y0)>>SCALE_LOG2:
//   - in_box = display_on && hpos>=X0 && vpos>=Y0 && cx < NUM_DIGITS*PITCH && cy < 5.
//  Stage 1 (registered, 1 cycle):
//   - digit <= committed nibble at index cx/PITCH; index 0 is the most significant digit.
//   - line <= cy when in_box, otherwise 7 (digit <= 0).
//   - col_q <= cx % PITCH.
//   - draw_q <= in_box && col_q<5 (i.e. the cell column cx % PITCH is < 5).
//  Stage 2 (registered): pixel <= draw_q && bits[4-col_q].
//  Latency: pixel is valid 2 clocks after the hpos/vpos it belongs to; digit/line are valid 1 clock after.
//  Boundaries:
//   - hpos<X0 or vpos<Y0: no underflow aliasing; the subtraction is guarded by the compare.
//   - The last digit's gap columns draw 0.
//   - display_on low forces pixel 0 two cycles later.
//  Reset mid-frame: outputs return to reset values immediately; drawing resumes on the next valid beam position, but shows 0s until the next frame-start commit.
// STRUCTURE
//  Shared package holds: GLYPH_W=5, GLYPH_H=5, LINE_BLANK=3'd7, and a BCD digit typedef (4 bits).
//  One natural sub-module: bcd_adder_digit (4-bit BCD add with carry in/out), instantiated NUM_DIGITS times in a ripple chain.
//  The decoder and bitmap stages are instantiated by the parent, not inside this block.
// TESTING
//  1. Reset with score_inc held high -> score_bcd=0000, pixel=0, line=7; after release and one frame, score_bcd=0001.
//  2. Score 0098 plus inc(add=5) -> working score 0103; score_bcd stays 0098 until the cycle after (0,0), then reads 0103.
//  3. Score 9997 plus inc(add=4) -> 0001 with overflow=1; a following score_clr -> 0000 with overflow=0; clr+inc in the same cycle -> 0000.
//  4. Score 0008 displayed with defaults (SCALE_LOG2=2, PITCH=8), using a decoder/bitmap model:
//     - Beam at (X0+96, Y0) -> digit=8, line=0 one clock later; pixel=1 two clocks later.
//     - Beam at (X0+20, Y0) (digit 0, cell column 5, a gap column) -> pixel=0.
//  5. Beam at (X0+128, Y0), i.e. cx=32 past the last digit -> line=7, pixel=0; beam at vpos=Y0+20 -> line=7.
//  6. score_add=12 with inc -> no change; async reset asserted mid-line -> pixel drops to 0 within the same cycle.

Source files
------------

// File: rtl/score_digit_renderer_pkg.sv
// Shared constants and types for the score digit renderer.
// Glyph geometry, the blank line code and BCD digit helpers live here.
package score_digit_renderer_pkg;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 5;
  localparam logic [2:0] LINE_BLANK = 3'd7;

  typedef logic [3:0] bcd_digit_t;

  // Deltas 10..15 are not decimal digits and must leave the score untouched.
  function automatic logic bcdValid(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/score_digit_renderer_adder.sv
// One decimal digit of the score adder: 4-bit BCD add with carry in and out.
// Chained NUM_DIGITS times by the top to form a single-cycle ripple adder.
module bcd_adder_digit
  import score_digit_renderer_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       c_i,
  output bcd_digit_t sum_o,
  output logic       c_o
);

  logic [4:0] rawSum;

  // Binary sum corrected by +6 when it leaves the decimal range.
  always_comb begin
    rawSum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    sum_o  = rawSum[3:0];
    c_o    = 1'b0;
    if (rawSum > 5'd9) begin
      sum_o = 4'(rawSum + 5'd6);
      c_o   = 1'b1;
    end
  end

endmodule

// File: rtl/score_digit_renderer.sv
// Draws an N-digit BCD score: keeps the score, maps the beam onto digit/glyph
// line for the external decoder, and turns the returned bitmap row into a pixel.
module score_digit_renderer
  import score_digit_renderer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int X0         = 16,
  parameter int Y0         = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int PITCH      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8:0]              hpos,
  input  logic [8:0]              vpos,
  input  logic                    display_on,
  input  logic [3:0]              score_add,
  input  logic                    score_inc,
  input  logic                    score_clr,
  output logic [3:0]              digit,
  output logic [2:0]              line,
  input  logic [4:0]              bits,
  output logic                    pixel,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow
);

  localparam int SW         = 4 * NUM_DIGITS;
  localparam int PITCH_LOG2 = $clog2(PITCH);
  localparam int CW         = PITCH_LOG2;

  logic [SW-1:0]       workScore_q, workScore_d;
  logic [SW-1:0]       shownScore_q, shownScore_d;
  logic                overflow_q, overflow_d;
  logic [SW-1:0]       sumScore;
  logic [NUM_DIGITS:0] carry;

  logic [8:0]    dx, dy, cx, cy, digIdx;
  logic [CW-1:0] cellCol;
  logic          inBox;
  bcd_digit_t    digitSel;
  logic          bitSel;

  bcd_digit_t    digit_q, digit_d;
  logic [2:0]    line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic          draw_q, draw_d;
  logic          pixel_q, pixel_d;

  assign carry[0] = 1'b0;

  // Ripple chain: nibble 0 (least significant) receives the delta.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gAdder
    bcd_digit_t addend;
    assign addend = (g == 0) ? score_add : 4'd0;

    bcd_adder_digit uDigit (
      .a_i  (workScore_q[g*4 +: 4]),
      .b_i  (addend),
      .c_i  (carry[g]),
      .sum_o(sumScore[g*4 +: 4]),
      .c_o  (carry[g+1])
    );
  end

  // Working score updates; the displayed copy only follows it at frame start.
  always_comb begin
    workScore_d  = workScore_q;
    overflow_d   = overflow_q;
    shownScore_d = shownScore_q;
    if (score_clr) begin
      workScore_d = '0;
      overflow_d  = 1'b0;
    end else if (score_inc && bcdValid(score_add)) begin
      workScore_d = sumScore;
      if (carry[NUM_DIGITS]) overflow_d = 1'b1;
    end
    if (hpos == 9'd0 && vpos == 9'd0) shownScore_d = workScore_q;
  end

  // Beam-to-cell mapping; the compares guard against wrapped subtractions.
  always_comb begin
    dx      = hpos - 9'(X0);
    dy      = vpos - 9'(Y0);
    cx      = dx >> SCALE_LOG2;
    cy      = dy >> SCALE_LOG2;
    digIdx  = cx >> PITCH_LOG2;
    cellCol = cx[CW-1:0];
    inBox   = display_on && (hpos >= 9'(X0)) && (vpos >= 9'(Y0)) &&
              (cx < 9'(NUM_DIGITS * PITCH)) && (cy < 9'(GLYPH_H));
    digitSel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digIdx == 9'(i)) digitSel = shownScore_q[(NUM_DIGITS-1-i)*4 +: 4];
    end
    digit_d = inBox ? digitSel : 4'd0;
    line_d  = inBox ? cy[2:0] : LINE_BLANK;
    col_d   = cellCol;
    draw_d  = inBox && (cellCol < CW'(GLYPH_W));
  end

  // Bitmap column 0 is bits[4]; gap columns never reach the selector.
  always_comb begin
    bitSel = 1'b0;
    for (int c = 0; c < GLYPH_W; c++) begin
      if (col_q == CW'(c)) bitSel = bits[GLYPH_W-1-c];
    end
    pixel_d = draw_q && bitSel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      workScore_q  <= '0;
      shownScore_q <= '0;
      overflow_q   <= 1'b0;
      digit_q      <= '0;
      line_q       <= LINE_BLANK;
      col_q        <= '0;
      draw_q       <= 1'b0;
      pixel_q      <= 1'b0;
    end else begin
      workScore_q  <= workScore_d;
      shownScore_q <= shownScore_d;
      overflow_q   <= overflow_d;
      digit_q      <= digit_d;
      line_q       <= line_d;
      col_q        <= col_d;
      draw_q       <= draw_d;
      pixel_q      <= pixel_d;
    end
  end

  assign digit     = digit_q;
  assign line      = line_q;
  assign pixel     = pixel_q;
  assign score_bcd = shownScore_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer with a small decoder/bitmap model
// closing the digit/line -> bits loop.
module tb_score_digit_renderer;

  localparam logic [8:0] IDLE_H = 9'd400;
  localparam logic [8:0] IDLE_V = 9'd300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  hpos, vpos;
  logic        display_on;
  logic [3:0]  score_add;
  logic        score_inc, score_clr;
  logic [3:0]  digit;
  logic [2:0]  line;
  logic [4:0]  bits;
  logic        pixel;
  logic [15:0] score_bcd;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 5x5 font; row 0 is the top line and bit 4 the leftmost column.
  function automatic logic [4:0] glyphRow(input logic [3:0] d, input logic [2:0] ln);
    logic [24:0] g;
    case (d)
      4'd0:    g = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
      4'd1:    g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110};
      4'd2:    g = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
      4'd3:    g = {5'b11111, 5'b00001, 5'b01111, 5'b00001, 5'b11111};
      4'd4:    g = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
      4'd5:    g = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
      4'd6:    g = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
      4'd7:    g = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b00100};
      4'd8:    g = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
      4'd9:    g = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
      default: g = '0;
    endcase
    if (ln > 3'd4) return 5'b00000;
    return g[24 - 5*ln -: 5];
  endfunction

  assign bits = glyphRow(digit, line);

  score_digit_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .display_on(display_on),
    .score_add (score_add),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .digit     (digit),
    .line      (line),
    .bits      (bits),
    .pixel     (pixel),
    .score_bcd (score_bcd),
    .overflow  (overflow)
  );

  // Drives one cycle of inputs from a negedge to the next negedge; inc/clr are pulses.
  task automatic applyStimulus(input logic [8:0] h, input logic [8:0] v, input logic don,
                               input logic [3:0] add, input logic inc, input logic clr);
    hpos       = h;
    vpos       = v;
    display_on = don;
    score_add  = add;
    score_inc  = inc;
    score_clr  = clr;
    @(negedge clk);
    score_inc  = 1'b0;
    score_clr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic inc, input logic [3:0] add);
    applyStimulus(9'd0, 9'd0, 1'b1, add, inc, 1'b0);
  endtask

  task automatic incBy(input logic [3:0] add);
    applyStimulus(IDLE_H, IDLE_V, 1'b1, add, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    hpos       = IDLE_H;
    vpos       = IDLE_V;
    display_on = 1'b1;
    score_add  = 4'd1;
    score_inc  = 1'b1;
    score_clr  = 1'b0;
    $display("[TB] reset with score_inc held high");
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset score_bcd", 32'(score_bcd), 32'h0000);
    checkOutput("reset pixel", 32'(pixel), 32'h0);
    checkOutput("reset line", 32'(line), 32'h7);
    checkOutput("reset digit", 32'(digit), 32'h0);
    checkOutput("reset overflow", 32'(overflow), 32'h0);
    reset_n   = 1'b1;
    score_inc = 1'b0;
    idle();
    incBy(4'd1);
    idle();
    frame(1'b0, 4'd0);
    checkOutput("first frame score", 32'(score_bcd), 32'h0001);

    $display("[TB] commit timing");
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) incBy(4'd9);
    incBy(4'd8);
    frame(1'b0, 4'd0);
    checkOutput("score 0098", 32'(score_bcd), 32'h0098);
    incBy(4'd5);
    idle();
    checkOutput("pre-commit hold", 32'(score_bcd), 32'h0098);
    frame(1'b1, 4'd1);
    checkOutput("commit 0103", 32'(score_bcd), 32'h0103);
    idle();
    frame(1'b0, 4'd0);
    checkOutput("late inc 0104", 32'(score_bcd), 32'h0104);

    $display("[TB] overflow and clear");
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 1110; i++) incBy(4'd9);
    incBy(4'd7);
    frame(1'b0, 4'd0);
    checkOutput("score 9997", 32'(score_bcd), 32'h9997);
    checkOutput("no overflow yet", 32'(overflow), 32'h0);
    incBy(4'd4);
    checkOutput("overflow set", 32'(overflow), 32'h1);
    frame(1'b0, 4'd0);
    checkOutput("wrap 0001", 32'(score_bcd), 32'h0001);
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd0, 1'b0, 1'b1);
    checkOutput("clr overflow", 32'(overflow), 32'h0);
    frame(1'b0, 4'd0);
    checkOutput("clr score", 32'(score_bcd), 32'h0000);
    incBy(4'd3);
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd5, 1'b1, 1'b1);
    frame(1'b0, 4'd0);
    checkOutput("clr beats inc", 32'(score_bcd), 32'h0000);

    $display("[TB] rendering score 0008");
    incBy(4'd8);
    frame(1'b0, 4'd0);
    checkOutput("score 0008", 32'(score_bcd), 32'h0008);
    applyStimulus(9'd112, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("digit3 code", 32'(digit), 32'h8);
    checkOutput("digit3 line", 32'(line), 32'h0);
    idle();
    checkOutput("digit3 pixel", 32'(pixel), 32'h1);
    applyStimulus(9'd116, 9'd12, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("inner line", 32'(line), 32'h1);
    idle();
    checkOutput("inner col1 pixel", 32'(pixel), 32'h0);
    applyStimulus(9'd128, 9'd12, 1'b1, 4'd0, 1'b0, 1'b0);
    idle();
    checkOutput("col4 pixel", 32'(pixel), 32'h1);
    applyStimulus(9'd16, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("digit0 code", 32'(digit), 32'h0);
    idle();
    checkOutput("digit0 pixel", 32'(pixel), 32'h1);
    applyStimulus(9'd36, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("gap line", 32'(line), 32'h0);
    idle();
    checkOutput("gap pixel", 32'(pixel), 32'h0);

    $display("[TB] box boundaries");
    applyStimulus(9'd144, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("past last digit line", 32'(line), 32'h7);
    idle();
    checkOutput("past last digit pixel", 32'(pixel), 32'h0);
    applyStimulus(9'd112, 9'd28, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("below box line", 32'(line), 32'h7);
    applyStimulus(9'd4, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("left of box line", 32'(line), 32'h7);
    applyStimulus(9'd112, 9'd2, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("above box line", 32'(line), 32'h7);
    applyStimulus(9'd112, 9'd8, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("blanked line", 32'(line), 32'h7);
    idle();
    checkOutput("blanked pixel", 32'(pixel), 32'h0);

    $display("[TB] invalid delta and async reset");
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd12, 1'b1, 1'b0);
    applyStimulus(IDLE_H, IDLE_V, 1'b1, 4'd15, 1'b1, 1'b0);
    frame(1'b0, 4'd0);
    checkOutput("invalid delta ignored", 32'(score_bcd), 32'h0008);
    checkOutput("invalid delta overflow", 32'(overflow), 32'h0);
    applyStimulus(9'd112, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(9'd112, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("drawing before reset", 32'(pixel), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("async pixel", 32'(pixel), 32'h0);
    checkOutput("async line", 32'(line), 32'h7);
    checkOutput("async score", 32'(score_bcd), 32'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(9'd112, 9'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("post-reset digit", 32'(digit), 32'h0);
    checkOutput("post-reset line", 32'(line), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
